window_3x3_gen: RTL and testbench

- Downstream neighbour of the line-delay stage in the Conv2D3x3 datapath.
- Consumes a raster-order pixel stream and assembles the full 3x3 neighbourhood for each pixel, using two internal row memories and a 3-column shift window.
- Emits one registered 9-pixel window per valid (no-padding) output position, with a valid pulse and an end-of-frame marker.
- Feeds the MAC/kernel stage.

---
 rtl/window_3x3_gen.sv | 95 +++++++++
 tb/tb_window_3x3_gen.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
// 3x3 neighbourhood generator: two row memories plus a 3-column shift window over a raster pixel stream.
// One window per interior pixel, registered 1 cycle after that pixel; no backpressure (one pixel per valid cycle).
module window_3x3_gen #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic               i_wr_valid,
  input  logic [WIDTH-1:0]   i_wr_data,
  output logic               o_rd_valid,
  output logic [9*WIDTH-1:0] o_rd_data,
  output logic               o_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [WIDTH-1:0] line1_q [IMG_W];
  logic [WIDTH-1:0] line2_q [IMG_W];
  logic [WIDTH-1:0] win_q   [3][3];
  logic [WIDTH-1:0] win_d   [3][3];
  logic [CW-1:0]    c_q, c_d;
  logic [RW-1:0]    r_q, r_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic             c_last, r_last;

  assign c_last = (c_q == CW'(IMG_W - 1));
  assign r_last = (r_q == RW'(IMG_H - 1));

  always_comb begin
    win_d  = win_q;
    c_d    = c_q;
    r_d    = r_q;
    vld_d  = 1'b0;
    last_d = 1'b0;
    if (i_wr_valid) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      // Memory reads here see the contents before this cycle's write.
      win_d[0][2] = line2_q[c_q];
      win_d[1][2] = line1_q[c_q];
      win_d[2][2] = i_wr_data;
      vld_d       = (r_q >= RW'(2)) && (c_q >= CW'(2));
      last_d      = r_last && c_last;
      if (c_last) begin
        c_d = '0;
        r_d = r_last ? '0 : r_q + RW'(1);
      end else begin
        c_d = c_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      win_q  <= '{default: '0};
      c_q    <= '0;
      r_q    <= '0;
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      win_q  <= win_d;
      c_q    <= c_d;
      r_q    <= r_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  // Row memories are unreset; the r >= 2 gate keeps stale rows from ever reaching the output.
  always_ff @(posedge i_clk) begin
    if (i_wr_valid) begin
      line2_q[c_q] <= line1_q[c_q];
      line1_q[c_q] <= i_wr_data;
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        o_rd_data[WIDTH*(3*i+j) +: WIDTH] = win_q[i][j];
      end
    end
  end

  assign o_rd_valid = vld_q;
  assign o_last     = last_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen on a 4x4 image with pixel (r,c) = base + 4r + c + 1.
module tb_window_3x3_gen;

  localparam int WIDTH = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;

  logic               i_clk;
  logic               i_resetn;
  logic               i_wr_valid;
  logic [WIDTH-1:0]   i_wr_data;
  logic               o_rd_valid;
  logic [9*WIDTH-1:0] o_rd_data;
  logic               o_last;

  window_3x3_gen #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .i_clk      (i_clk),
    .i_resetn   (i_resetn),
    .i_wr_valid (i_wr_valid),
    .i_wr_data  (i_wr_data),
    .o_rd_valid (o_rd_valid),
    .o_rd_data  (o_rd_data),
    .o_last     (o_last)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct packed {
    logic               vld;
    logic               last;
    logic               chk;
    logic [9*WIDTH-1:0] dat;
  } exp_t;

  exp_t               exp_q[$];
  logic [9*WIDTH-1:0] last_win;
  logic               last_win_ok;
  int                 checks;
  int                 failures;

  function automatic logic [9*WIDTH-1:0] win_of(input int base, input int r, input int c);
    logic [9*WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[WIDTH*(3*i+j) +: WIDTH] = WIDTH'(base + IMG_W*(r-2+i) + (c-2+j) + 1);
    return w;
  endfunction

  // Drives one pixel and queues what the DUT must show one cycle later.
  task automatic put_pixel(input int base, input int r, input int c);
    exp_t e;
    i_wr_valid = 1'b1;
    i_wr_data  = WIDTH'(base + IMG_W*r + c + 1);
    e.vld  = (r >= 2) && (c >= 2);
    e.last = (r == IMG_H-1) && (c == IMG_W-1);
    e.chk  = e.vld;
    e.dat  = e.vld ? win_of(base, r, c) : '0;
    if (e.vld) begin
      last_win    = e.dat;
      last_win_ok = 1'b1;
    end else begin
      last_win_ok = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  task automatic put_idle();
    exp_t e;
    i_wr_valid = 1'b0;
    i_wr_data  = 8'hEE;
    e.vld  = 1'b0;
    e.last = 1'b0;
    e.chk  = last_win_ok;
    e.dat  = last_win;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    i_resetn   = 1'b0;
    i_wr_valid = 1'b0;
    i_wr_data  = '0;
    repeat (2) @(negedge i_clk);
    i_resetn = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge i_clk);
      checks++;
      if (o_rd_valid !== 1'b0 || o_last !== 1'b0 || o_rd_data !== '0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: valid=%b last=%b data=%h, required 0/0/0",
                 n, o_rd_valid, o_last, o_rd_data);
      end
    end
  endtask

  task automatic test_stream_frame();
    exp_t e;
    int   wins = 0;
    for (int n = 0; n < IMG_W*IMG_H; n++) begin
      put_pixel(0, n / IMG_W, n % IMG_W);
      @(negedge i_clk);
      e = exp_q.pop_front();
      checks++;
      if (o_rd_valid !== e.vld || o_last !== e.last) begin
        failures++;
        $display("FAIL stream_flags pixel %0d: valid=%b last=%b, required %b/%b",
                 n+1, o_rd_valid, o_last, e.vld, e.last);
      end
      if (e.chk) begin
        checks++;
        if (o_rd_data !== e.dat) begin
          failures++;
          $display("FAIL stream_window pixel %0d: got %h, required %h", n+1, o_rd_data, e.dat);
        end
      end
      if (o_rd_valid === 1'b1) wins++;
    end
    i_wr_valid = 1'b0;
    checks++;
    if (wins != 4) begin
      failures++;
      $display("FAIL stream_count: got %0d windows, required 4", wins);
    end
  endtask

  task automatic test_toggle();
    exp_t e;
    int   wins = 0;
    for (int n = 0; n < 2*IMG_W*IMG_H; n++) begin
      if (n % 2 == 0) put_pixel(0, (n/2) / IMG_W, (n/2) % IMG_W);
      else            put_idle();
      @(negedge i_clk);
      e = exp_q.pop_front();
      checks++;
      if (o_rd_valid !== e.vld || o_last !== e.last) begin
        failures++;
        $display("FAIL toggle_flags step %0d: valid=%b last=%b, required %b/%b",
                 n, o_rd_valid, o_last, e.vld, e.last);
      end
      if (e.chk) begin
        checks++;
        if (o_rd_data !== e.dat) begin
          failures++;
          $display("FAIL toggle_window step %0d: got %h, required %h", n, o_rd_data, e.dat);
        end
      end
      if (o_rd_valid === 1'b1) wins++;
    end
    i_wr_valid = 1'b0;
    checks++;
    if (wins != 4) begin
      failures++;
      $display("FAIL toggle_count: got %0d windows, required 4", wins);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   wins = 0;
    for (int n = 0; n < 2*IMG_W*IMG_H; n++) begin
      put_pixel((n < IMG_W*IMG_H) ? 0 : 100, (n / IMG_W) % IMG_H, n % IMG_W);
      @(negedge i_clk);
      e = exp_q.pop_front();
      checks++;
      if (o_rd_valid !== e.vld || o_last !== e.last) begin
        failures++;
        $display("FAIL b2b_flags pixel %0d: valid=%b last=%b, required %b/%b",
                 n+1, o_rd_valid, o_last, e.vld, e.last);
      end
      if (e.chk) begin
        checks++;
        if (o_rd_data !== e.dat) begin
          failures++;
          $display("FAIL b2b_window pixel %0d: got %h, required %h", n+1, o_rd_data, e.dat);
        end
      end
      if (o_rd_valid === 1'b1) wins++;
    end
    i_wr_valid = 1'b0;
    checks++;
    if (wins != 8) begin
      failures++;
      $display("FAIL b2b_count: got %0d windows, required 8", wins);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int   wins = 0;
    int   p;
    for (int n = 0; n < 9 + IMG_W*IMG_H; n++) begin
      if (n == 9) begin
        i_wr_valid = 1'b0;
        i_resetn   = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge i_clk);
          checks++;
          if (o_rd_valid !== 1'b0 || o_last !== 1'b0 || o_rd_data !== '0) begin
            failures++;
            $display("FAIL midreset_hold cycle %0d: valid=%b last=%b data=%h, required 0/0/0",
                     k, o_rd_valid, o_last, o_rd_data);
          end
        end
        i_resetn = 1'b1;
      end
      p = (n < 9) ? n : n - 9;
      put_pixel(0, p / IMG_W, p % IMG_W);
      @(negedge i_clk);
      e = exp_q.pop_front();
      checks++;
      if (o_rd_valid !== e.vld || o_last !== e.last) begin
        failures++;
        $display("FAIL midreset_flags step %0d: valid=%b last=%b, required %b/%b",
                 n, o_rd_valid, o_last, e.vld, e.last);
      end
      if (e.chk) begin
        checks++;
        if (o_rd_data !== e.dat) begin
          failures++;
          $display("FAIL midreset_window step %0d: got %h, required %h", n, o_rd_data, e.dat);
        end
      end
      if (o_rd_valid === 1'b1) wins++;
    end
    i_wr_valid = 1'b0;
    checks++;
    if (wins != 4) begin
      failures++;
      $display("FAIL midreset_count: got %0d windows, required 4", wins);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    last_win    = '0;
    last_win_ok = 1'b0;
    test_reset();
    test_stream_frame();
    test_toggle();
    test_back_to_back();
    test_mid_reset();
    @(negedge i_clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
